// File: rtl/cla_adder4_pkg.sv
// Shared constants for the 4-bit carry-lookahead adder slice.
// The lookahead equations are hand-expanded, so the slice width is fixed here.
package cla_adder4_pkg;

  localparam int CLA_WIDTH = 4;

endpackage

// File: rtl/cla_adder4_lookahead4.sv
// Combinational 4-bit carry-lookahead network: per-bit generate/propagate to carries c1..c4.
// Every carry is a flat sum-of-products of g, p and c_in, so no carry ripples through another.
module cla_adder4_lookahead4
  import cla_adder4_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] i_g,
  input  logic [CLA_WIDTH-1:0] i_p,
  input  logic                 i_c_in,
  output logic [CLA_WIDTH:1]   o_c
);

  assign o_c[1] = i_g[0]
                | (i_p[0] & i_c_in);

  assign o_c[2] = i_g[1]
                | (i_p[1] & i_g[0])
                | (i_p[1] & i_p[0] & i_c_in);

  assign o_c[3] = i_g[2]
                | (i_p[2] & i_g[1])
                | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c_in);

  assign o_c[4] = i_g[3]
                | (i_p[3] & i_g[2])
                | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
                | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c_in);

endmodule

// File: rtl/cla_adder4.sv
// 4-bit carry-lookahead adder slice with a registered sum and a one-cycle ready flag.
// c_out is combinational so a chain of slices settles within one clock period.
module cla_adder4
  import cla_adder4_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             c_in,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ready
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:1]   w_c_hi;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_ready;

  assign w_g = A & B;
  assign w_p = A ^ B;

  cla_adder4_lookahead4 u_lookahead (
    .i_g    (w_g),
    .i_p    (w_p),
    .i_c_in (c_in),
    .o_c    (w_c_hi)
  );

  assign w_carry = {w_c_hi, c_in};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign w_sum[gi] = w_p[gi] ^ w_carry[gi];
    end
  endgenerate

  // Reset wins over en; a disabled edge keeps the sum but drops ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum   <= '0;
      r_ready <= 1'b0;
    end else if (en) begin
      r_sum   <= w_sum;
      r_ready <= 1'b1;
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign Output = r_sum;
  assign ready  = r_ready;
  assign c_out  = w_carry[WIDTH];

endmodule

// File: tb/tb_cla_adder4.sv
// Directed and exhaustive checks of cla_adder4, plus a 4-slice 16-bit chain.
module tb_cla_adder4;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_in;
  logic       en;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Output;
  logic       c_out;
  logic       ready;

  logic [15:0] ch_a;
  logic [15:0] ch_b;
  logic [15:0] ch_sum;
  logic [4:0]  ch_c;
  logic [3:0]  ch_rdy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cla_adder4 dut (
    .clk    (clk),
    .reset  (reset),
    .c_in   (c_in),
    .en     (en),
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
  );

  assign ch_c[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chain
      cla_adder4 u_slice (
        .clk    (clk),
        .reset  (reset),
        .c_in   (ch_c[gi]),
        .en     (en),
        .A      (ch_a[gi*4 +: 4]),
        .B      (ch_b[gi*4 +: 4]),
        .Output (ch_sum[gi*4 +: 4]),
        .c_out  (ch_c[gi+1]),
        .ready  (ch_rdy[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; c_in = 1'b0; A = 4'd5; B = 4'd3;
    ch_a = 16'h0000; ch_b = 16'h0000;

    // Reset held two cycles with en=1
    edge_tick();
    check("rst1_out", 32'(Output), 32'd0);
    check("rst1_rdy", 32'(ready), 32'd0);
    edge_tick();
    check("rst2_out", 32'(Output), 32'd0);
    check("rst2_rdy", 32'(ready), 32'd0);
    reset = 1'b0;
    edge_tick();
    check("rel_out", 32'(Output), 32'd8);
    check("rel_rdy", 32'(ready), 32'd1);

    // Plain add
    A = 4'd3; B = 4'd4; c_in = 1'b0; #1;
    check("add_cout", 32'(c_out), 32'd0);
    edge_tick();
    check("add_out", 32'(Output), 32'd7);
    check("add_rdy", 32'(ready), 32'd1);

    // Wrap-around
    A = 4'd15; B = 4'd1; c_in = 1'b0; #1;
    check("wrap_cout", 32'(c_out), 32'd1);
    edge_tick();
    check("wrap_out", 32'(Output), 32'd0);

    A = 4'd15; B = 4'd15; c_in = 1'b1; #1;
    check("max_cout", 32'(c_out), 32'd1);
    edge_tick();
    check("max_out", 32'(Output), 32'd15);

    // Subtract-style: 9 - 2 as 9 + ~2 + 1
    A = 4'd9; B = 4'd13; c_in = 1'b1; #1;
    check("sub_cout", 32'(c_out), 32'd1);
    edge_tick();
    check("sub_out", 32'(Output), 32'd7);

    // Enable hold
    A = 4'd2; B = 4'd2; c_in = 1'b0;
    edge_tick();
    check("hold_cap", 32'(Output), 32'd4);
    en = 1'b0; A = 4'd6; #1;
    check("hold_cout6", 32'(c_out), 32'd0);
    edge_tick();
    check("hold_out", 32'(Output), 32'd4);
    check("hold_rdy", 32'(ready), 32'd0);
    A = 4'd14; #1;
    check("hold_cout14", 32'(c_out), 32'd1);
    edge_tick();
    check("hold_out2", 32'(Output), 32'd4);

    // Reset mid-operation with en=1 discards the result
    en = 1'b1; A = 4'd1; B = 4'd1;
    edge_tick();
    check("pre_mid_out", 32'(Output), 32'd2);
    A = 4'd7; B = 4'd5; reset = 1'b1;
    edge_tick();
    check("mid_rst_out", 32'(Output), 32'd0);
    check("mid_rst_rdy", 32'(ready), 32'd0);
    reset = 1'b0;

    // Exhaustive A/B/c_in sweep with en held high
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          A = 4'(a); B = 4'(b); c_in = 1'(c);
          edge_tick();
          check($sformatf("exh_%0d_%0d_%0d", a, b, c), 32'({c_out, Output}), 32'(a + b + c));
        end
      end
    end
    check("exh_rdy", 32'(ready), 32'd1);

    // 16-bit chain: 0xFFFF + 0x0001
    ch_a = 16'hFFFF; ch_b = 16'h0001;
    edge_tick();
    check("chain_sum", 32'(ch_sum), 32'h0000);
    check("chain_cout", 32'(ch_c[4]), 32'd1);
    check("chain_rdy", 32'(ch_rdy), 32'hF);

    ch_a = 16'h1234; ch_b = 16'h0FCD;
    edge_tick();
    check("chain_sum2", 32'({ch_c[4], ch_sum}), 32'h02201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cla_adder4.md
Name: cla_adder4

Overview:
- 4-bit carry-lookahead adder slice with a registered sum and a one-cycle ready flag.
- Four instances chain carry-to-carry to build the 16-bit add/subtract unit.
- The parent XORs B with the subtract flag and drives c_in; this block only adds.
- Carry-out is combinational, so a chain of slices resolves within one clock period.

Parameters:
- WIDTH, 4, operand width in bits. The lookahead network is written for 4; other values are not supported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- c_in  input  1  carry into bit 0.
- en  input  1  capture enable for the sum register.
- A  input  4  operand A.
- B  input  4  operand B, already conditioned by the parent.
- Output  output  4  registered sum A+B+c_in (low 4 bits).
- c_out  output  1  combinational carry out of bit 3.
- ready  output  1  registered flag: Output holds a valid result.

Behaviour:
- Per bit: g[i]=A[i]&B[i], p[i]=A[i]^B[i].
- Lookahead carries, all computed directly from g, p and c_in (no ripple through sum logic):
  - c1=g0|p0&c_in
  - c2=g1|p1&g0|p1&p0&c_in
  - c3, c4 follow the same expansion.
- Sum bit s[i]=p[i]^c[i], with c0=c_in.
- c_out=c4, purely combinational from A, B, c_in. It is not gated by en or reset.
- Synchronous reset (reset=1 at a rising edge): Output<=0, ready<=0. Reset overrides en.
- en=1 at a rising edge, no reset: Output<=s, ready<=1. Latency from en sample to valid Output/ready is 1 cycle.
- en=0 at a rising edge, no reset: Output holds its last value, ready<=0.
- en held high: Output re-captures every cycle and tracks input changes with 1-cycle delay. ready stays 1.
- Wrap-around: Output is the sum mod 16, e.g. 15+1+0 gives Output=0, c_out=1.
- Inputs changing between edges have no effect on Output until the next enabled edge. c_out follows immediately.
- Reset asserted mid-operation (with en=1): the result is discarded; Output=0 and ready=0 on the next cycle.
- No X-propagation protection is required. After reset, all outputs must be known values.

Decomposition:
- No package needed; WIDTH is local.
- A natural sub-module is cla_lookahead4: combinational g/p to c1..c4, plus optional group P/G outputs for future two-level lookahead.
- The top level adds the sum XORs and the Output/ready registers.

Test Plan:
- Reset: reset=1 for 2 cycles, with en=1, A=5, B=3 -> Output=0, ready=0. Then release: next edge gives Output=8, ready=1.
- Plain add: A=3, B=4, c_in=0, en=1 -> after 1 edge Output=7, ready=1; c_out=0 immediately.
- Carry/wrap: A=15, B=1, c_in=0 -> c_out=1 combinationally; after the edge Output=0.
  - Same with A=15, B=15, c_in=1 -> Output=15, c_out=1.
- Subtract-style input: A=9, B=~2 (13), c_in=1 -> Output=7, c_out=1.
- Enable hold: capture A=2, B=2 (Output=4), then en=0 and A=6 -> Output stays 4, ready=0 next cycle; c_out reflects the new inputs.
- Exhaustive: all 512 A/B/c_in combinations with en=1 -> {c_out,Output} equals A+B+c_in after each edge.
  - Also chain 4 instances as a 16-bit adder and check 0xFFFF+0x0001 -> 0x0000, final c_out=1, all ready=1 after one cycle.
